decode_stage: RTL
=================

Name: decode_stage

Overview:
- Registered instruction-decode pipeline stage for the 16-bit SIMPLE-style core.
- Splits the instruction into its fields and classifies it into an operation kind.
- Sign-extends the displacement to a parametrised datapath width.
- Sits between fetch and register-read. Uses a valid/ready handshake with flush and a sticky halt, and carries the PC alongside the instruction.

Parameters:
DATA_W, 16, datapath width for the extended immediate; legal range 8..64.
PC_W, 16, width of the PC carried with each instruction.
HALT_STICKY, 1, 1 = after HLT is accepted, no further instructions are accepted until flush or reset; 0 = HLT is classified only.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  drop the held instruction and clear halt
in_valid  in  1  fetch presents an instruction
in_ready  out  1  stage can accept this cycle
in_instr  in  16  instruction word
in_pc  in  PC_W  PC of in_instr
out_valid  out  1  decoded instruction held
out_ready  in  1  downstream accepts this cycle
out_pc  out  PC_W  registered PC
out_op1  out  2  instr[15:14]
out_ra  out  3  instr[13:11]: Rs, Ra or op2
out_rb  out  3  instr[10:8]: Rd, Rb or cond
out_op3  out  4  instr[7:4]
out_cond  out  3  instr[10:8] when kind is BCOND, else 0
out_imm  out  DATA_W  instr[7:0] sign-extended to DATA_W
out_shamt  out  4  instr[3:0]
out_kind  out  4  operation class (encoding below)
halted  out  1  sticky-halt flag

Behaviour:
- out_kind encoding: ALU=0, SHIFT=1, IN=2, OUT=3, HALT=4, LD=5, ST=6, LI=7, B=8, BCOND=9, ILLEGAL=15.
- Classification, op1=11 (by op3):
  - 0000-0110 -> ALU (ADD, SUB, AND, OR, XOR, CMP, MOV)
  - 1000-1011 -> SHIFT
  - 1100 -> IN; 1101 -> OUT; 1111 -> HALT
  - 0111 and 1110 -> ILLEGAL
- Classification, op1=10 (by op2 = instr[13:11]):
  - 000 -> LI; 100 -> B; 111 -> BCOND
  - any other value -> ILLEGAL
- Classification, op1=00 -> LD; op1=01 -> ST.
- ILLEGAL is passed downstream with out_valid; this stage does not trap.
- All decoded outputs are registered and captured only on an input transfer. Latency is 1 cycle from in_valid&&in_ready to out_valid.
- Handshake:
  - in_ready = !halted && (!out_valid || out_ready), combinational.
  - Input transfer: in_valid && in_ready.
  - Output transfer: out_valid && out_ready.
  - Simultaneous output and input transfer in one cycle: new data loads and out_valid stays 1. Full throughput, one instruction per cycle.
  - Output transfer with no input transfer: out_valid goes 0 next cycle.
  - While out_valid=1 and out_ready=0, every out_* signal is held stable.
- Halt:
  - With HALT_STICKY=1, an input transfer whose kind is HALT sets halted=1 on the same edge.
  - The HLT itself is still presented downstream.
  - halted stays 1, holding in_ready=0, until flush or rst.
- Flush:
  - On an edge with flush=1: out_valid becomes 0 and halted becomes 0. Any input transfer in that cycle is discarded; flush has priority.
  - in_ready is not gated by flush.
- Reset, which overrides flush and may arrive mid-transfer: out_valid=0, halted=0, out_pc=0, out_op1=0, out_ra=0, out_rb=0, out_op3=0, out_cond=0, out_imm=0, out_shamt=0, out_kind=0.
- Data fields (out_*, excluding out_valid) are don't-care while out_valid=0. They must not change except on an input transfer or rst.
- Sign extension: out_imm = {(DATA_W-8){instr[7]}, instr[7:0]}. For DATA_W=8 this is a plain copy.

Test Plan:
- 0xD100 (ADD, Rs=2, Rd=1), pc=0x0010, out_ready=1 -> next cycle out_valid=1, kind=0, ra=2, rb=1, op3=0, pc=0x0010.
- 0x83FB (LI r3,-5), DATA_W=16 -> kind=7, rb=3, imm=0xFFFB. Repeat with DATA_W=32 -> imm=0xFFFFFFFB.
- Back-to-back 0x0A04 (LD), 0xB810 (BE cond=0, d=0x10), 0xC070 (illegal op3=0111) with out_ready=1 every cycle -> three consecutive out_valid cycles. Kinds 5, 9, 15; BE gives imm=0x0010, cond=0.
- Backpressure: out_ready=0 for 3 cycles with 0xB810 held -> in_ready=0, all outputs stable. Release -> next instruction follows with no loss or duplicate.
- 0xC0F0 (HLT), HALT_STICKY=1 -> kind=4 delivered, halted=1, in_ready=0 until flush. Flush pulse -> halted=0, out_valid=0, next instruction accepted. With HALT_STICKY=0 -> halted stays 0.
- rst asserted while out_valid=1 together with flush and in_valid -> next cycle out_valid=0, halted=0, out_kind=0, out_imm=0.

Source files
------------

// File: rtl/decode_stage.sv
// Registered decode stage for the 16-bit SIMPLE-style core.
// Splits instruction fields, classifies the operation and sign-extends the displacement.
module decode_stage #(
    parameter int DATA_W      = 16,
    parameter int PC_W        = 16,
    parameter bit HALT_STICKY = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_instr,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [1:0]        out_op1,
    output logic [2:0]        out_ra,
    output logic [2:0]        out_rb,
    output logic [3:0]        out_op3,
    output logic [2:0]        out_cond,
    output logic [DATA_W-1:0] out_imm,
    output logic [3:0]        out_shamt,
    output logic [3:0]        out_kind,
    output logic              halted
);

    localparam logic [3:0] K_ALU     = 4'd0;
    localparam logic [3:0] K_SHIFT   = 4'd1;
    localparam logic [3:0] K_IN      = 4'd2;
    localparam logic [3:0] K_OUT     = 4'd3;
    localparam logic [3:0] K_HALT    = 4'd4;
    localparam logic [3:0] K_LD      = 4'd5;
    localparam logic [3:0] K_ST      = 4'd6;
    localparam logic [3:0] K_LI      = 4'd7;
    localparam logic [3:0] K_B       = 4'd8;
    localparam logic [3:0] K_BCOND   = 4'd9;
    localparam logic [3:0] K_ILLEGAL = 4'd15;

    logic [1:0]        op1;
    logic [2:0]        op2;
    logic [3:0]        op3;
    logic [3:0]        kind;
    logic [DATA_W-1:0] imm_ext;
    logic              take;

    assign op1     = in_instr[15:14];
    assign op2     = in_instr[13:11];
    assign op3     = in_instr[7:4];
    assign imm_ext = DATA_W'($signed(in_instr[7:0]));

    assign in_ready = !halted && (!out_valid || out_ready);
    assign take     = in_valid && in_ready;

    always_comb begin
        kind = K_ILLEGAL;
        unique case (1'b1)
            op1 == 2'b00: kind = K_LD;
            op1 == 2'b01: kind = K_ST;
            op1 == 2'b10: begin
                case (op2)
                    3'b000:  kind = K_LI;
                    3'b100:  kind = K_B;
                    3'b111:  kind = K_BCOND;
                    default: kind = K_ILLEGAL;
                endcase
            end
            op1 == 2'b11: begin
                case (op3)
                    4'b0000, 4'b0001, 4'b0010, 4'b0011,
                    4'b0100, 4'b0101, 4'b0110: kind = K_ALU;
                    4'b1000, 4'b1001,
                    4'b1010, 4'b1011:          kind = K_SHIFT;
                    4'b1100:                   kind = K_IN;
                    4'b1101:                   kind = K_OUT;
                    4'b1111:                   kind = K_HALT;
                    default:                   kind = K_ILLEGAL;
                endcase
            end
            default: kind = K_ILLEGAL;
        endcase
    end

    // Flush wins over an accepted input; reset wins over both.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            halted    <= 1'b0;
            out_pc    <= '0;
            out_op1   <= '0;
            out_ra    <= '0;
            out_rb    <= '0;
            out_op3   <= '0;
            out_cond  <= '0;
            out_imm   <= '0;
            out_shamt <= '0;
            out_kind  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            halted    <= 1'b0;
        end else if (take) begin
            out_valid <= 1'b1;
            out_pc    <= in_pc;
            out_op1   <= op1;
            out_ra    <= in_instr[13:11];
            out_rb    <= in_instr[10:8];
            out_op3   <= op3;
            out_cond  <= (kind == K_BCOND) ? in_instr[10:8] : 3'd0;
            out_imm   <= imm_ext;
            out_shamt <= in_instr[3:0];
            out_kind  <= kind;
            if (HALT_STICKY && kind == K_HALT)
                halted <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
